// File: rtl/hamming_secded_dec.sv
// Pipelined SECDED (extended Hamming) decoder with valid/ready streaming on
// both sides and saturating single/double error counters.
// Stage S1 computes syndrome and overall parity; stage S2 classifies,
// corrects and extracts the data bits.
module hamming_secded_dec #(
    parameter int M     = 4,
    parameter int CNT_W = 16,
    localparam int N    = 1 << M,
    localparam int K    = N - M - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_code,
    input  logic             corr_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [K-1:0]     out_data,
    output logic             out_single,
    output logic             out_double,
    output logic [M-1:0]     out_err_pos,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] single_cnt,
    output logic [CNT_W-1:0] double_cnt
);

    // Codeword position holding data bit k: the k-th position >= 3 that is
    // not a power of two.
    function automatic int data_pos(input int k);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int j = 3; j < N; j++) begin
            if ((j & (j - 1)) != 0) begin
                if (cnt == k) pos = j;
                cnt++;
            end
        end
        return pos;
    endfunction

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Stage S1 state. Only the data positions of the codeword are kept: the
    // check bits are fully consumed by the syndrome and parity computed here.
    logic             s1_valid_q, s1_valid_d;
    logic [K-1:0]     s1_data_q,  s1_data_d;
    logic             s1_corr_q,  s1_corr_d;
    logic [M-1:0]     s1_syn_q,   s1_syn_d;
    logic             s1_par_q,   s1_par_d;

    // Stage S2 state (drives the outputs directly).
    logic             s2_valid_q,    s2_valid_d;
    logic [K-1:0]     out_data_q,    out_data_d;
    logic             out_single_q,  out_single_d;
    logic             out_double_q,  out_double_d;
    logic [M-1:0]     out_err_pos_q, out_err_pos_d;

    logic [CNT_W-1:0] single_cnt_q, single_cnt_d;
    logic [CNT_W-1:0] double_cnt_q, double_cnt_d;

    logic             s2_adv;
    logic             s1_adv;
    logic             out_hs;

    // Pipeline advance: a stage moves when it is empty or its successor moves.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign out_hs   = s2_valid_q && out_ready;

    // S1 next state: syndrome, overall parity and data extraction.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_corr_d  = s1_corr_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_corr_d = corr_en;
                s1_par_d  = ^in_code;
                s1_syn_d  = '0;
                for (int i = 0; i < M; i++) begin
                    for (int j = 1; j < N; j++) begin
                        if (((j >> i) & 1) == 1) s1_syn_d[i] = s1_syn_d[i] ^ in_code[j];
                    end
                end
                for (int k = 0; k < K; k++) begin
                    s1_data_d[k] = in_code[data_pos(k)];
                end
            end
        end
    end

    // S2 next state: classify and apply the single-bit correction.
    always_comb begin
        s2_valid_d    = s2_valid_q;
        out_data_d    = out_data_q;
        out_single_d  = out_single_q;
        out_double_d  = out_double_q;
        out_err_pos_d = out_err_pos_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_single_d  = s1_par_q;
                out_double_d  = !s1_par_q && (s1_syn_q != '0);
                out_err_pos_d = s1_syn_q;
                // Only a parity-flagged word is corrected; a double error is
                // passed through untouched.
                for (int k = 0; k < K; k++) begin
                    out_data_d[k] = s1_data_q[k] ^
                        (s1_par_q && s1_corr_q && (int'(s1_syn_q) == data_pos(k)));
                end
            end
        end
    end

    // Saturating error counters; clear wins over a same-cycle increment.
    always_comb begin
        single_cnt_d = single_cnt_q;
        double_cnt_d = double_cnt_q;
        if (clr_cnt) begin
            single_cnt_d = '0;
            double_cnt_d = '0;
        end else if (out_hs) begin
            if (out_single_q && single_cnt_q != CNT_MAX) single_cnt_d = single_cnt_q + CNT_W'(1);
            if (out_double_q && double_cnt_q != CNT_MAX) double_cnt_d = double_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset empties the pipeline and clears all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_data_q     <= '0;
            s1_corr_q     <= 1'b0;
            s1_syn_q      <= '0;
            s1_par_q      <= 1'b0;
            s2_valid_q    <= 1'b0;
            out_data_q    <= '0;
            out_single_q  <= 1'b0;
            out_double_q  <= 1'b0;
            out_err_pos_q <= '0;
            single_cnt_q  <= '0;
            double_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            s1_valid_q    <= s1_valid_d;
            s1_data_q     <= s1_data_d;
            s1_corr_q     <= s1_corr_d;
            s1_syn_q      <= s1_syn_d;
            s1_par_q      <= s1_par_d;
            s2_valid_q    <= s2_valid_d;
            out_data_q    <= out_data_d;
            out_single_q  <= out_single_d;
            out_double_q  <= out_double_d;
            out_err_pos_q <= out_err_pos_d;
            single_cnt_q  <= single_cnt_d;
            double_cnt_q  <= double_cnt_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_data    = out_data_q;
    assign out_single  = out_single_q;
    assign out_double  = out_double_q;
    assign out_err_pos = out_err_pos_q;
    assign single_cnt  = single_cnt_q;
    assign double_cnt  = double_cnt_q;

endmodule

// File: tb/tb_hamming_secded_dec.sv
// Scoreboard bench for hamming_secded_dec (M=4, CNT_W=2).
module tb_hamming_secded_dec;

    localparam int M     = 4;
    localparam int CNT_W = 2;
    localparam int N     = 16;
    localparam int K     = 11;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [K-1:0] data;
        logic         single;
        logic         dbl;
        logic [M-1:0] pos;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_code;
    logic             corr_en;
    logic             out_valid;
    logic             out_ready;
    logic [K-1:0]     out_data;
    logic             out_single;
    logic             out_double;
    logic [M-1:0]     out_err_pos;
    logic             clr_cnt;
    logic [CNT_W-1:0] single_cnt;
    logic [CNT_W-1:0] double_cnt;

    int checks = 0;
    int errors = 0;
    int pushed = 0;
    int flushed = 0;
    int delivered = 0;
    int exp_single_cnt = 0;
    int exp_double_cnt = 0;
    exp_t q[$];

    logic         prev_stall = 1'b0;
    logic [K-1:0] prev_data;
    logic         prev_single;
    logic         prev_double;
    logic [M-1:0] prev_pos;

    hamming_secded_dec #(.M(M), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .corr_en(corr_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_single(out_single), .out_double(out_double), .out_err_pos(out_err_pos),
        .clr_cnt(clr_cnt), .single_cnt(single_cnt), .double_cnt(double_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: data into non-power positions, then check bits, then overall parity.
    function automatic logic [N-1:0] encode(input logic [K-1:0] d);
        logic [N-1:0] c;
        int k;
        logic p;
        c = '0;
        k = 0;
        for (int j = 3; j < N; j++) begin
            if (j != 4 && j != 8) begin
                c[j] = d[k];
                k++;
            end
        end
        for (int i = 0; i < M; i++) begin
            p = 1'b0;
            for (int j = 1; j < N; j++) begin
                if (((j >> i) & 1) == 1 && j != (1 << i)) p = p ^ c[j];
            end
            c[1 << i] = p;
        end
        c[0] = ^c[N-1:1];
        return c;
    endfunction

    // Output monitor: scoreboard pop, stall stability and counter model.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            check("single_cnt", 32'(single_cnt), 32'(exp_single_cnt));
            check("double_cnt", 32'(double_cnt), 32'(exp_double_cnt));
            if (prev_stall) begin
                check("stall_valid",  32'(out_valid),   32'(1));
                check("stall_data",   32'(out_data),    32'(prev_data));
                check("stall_single", 32'(out_single),  32'(prev_single));
                check("stall_double", 32'(out_double),  32'(prev_double));
                check("stall_pos",    32'(out_err_pos), 32'(prev_pos));
            end
            if (out_valid && out_ready) begin
                check("out_expected", 32'(q.size() != 0), 32'(1));
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("out_data",   32'(out_data),    32'(e.data));
                    check("out_single", 32'(out_single),  32'(e.single));
                    check("out_double", 32'(out_double),  32'(e.dbl));
                    check("out_pos",    32'(out_err_pos), 32'(e.pos));
                    delivered++;
                    if (!clr_cnt) begin
                        if (e.single && exp_single_cnt < CMAX) exp_single_cnt++;
                        if (e.dbl && exp_double_cnt < CMAX) exp_double_cnt++;
                    end
                end
            end
            if (clr_cnt) begin
                exp_single_cnt = 0;
                exp_double_cnt = 0;
            end
            prev_stall  = out_valid && !out_ready;
            prev_data   = out_data;
            prev_single = out_single;
            prev_double = out_double;
            prev_pos    = out_err_pos;
        end
    end

    task automatic send(input logic [N-1:0] code, input logic corr, input exp_t e);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_code  = code;
        corr_en  = corr;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                pushed++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        check("send_accepted", 32'(done), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(q.size()), 32'(0));
    endtask

    initial begin
        logic [K-1:0] d;
        logic [N-1:0] c;
        logic [K-1:0] w[8];
        int idx;
        bit saw_low;

        rst_n = 1'b0; in_valid = 1'b0; in_code = '0; corr_en = 1'b1;
        out_ready = 1'b1; clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid",  32'(out_valid),  32'(0));
        check("rst_in_ready",   32'(in_ready),   32'(1));
        check("rst_out_data",   32'(out_data),   32'(0));
        check("rst_single_cnt", 32'(single_cnt), 32'(0));
        check("rst_double_cnt", 32'(double_cnt), 32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed words, with a latency check on the first.
        send(16'h0000, 1'b1, '{data: 11'h000, single: 1'b0, dbl: 1'b0, pos: 4'd0});
        check("lat_cycle1", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;
        check("lat_cycle2", 32'(out_valid), 32'(1));
        send(16'hFFFF, 1'b1, '{data: 11'h7FF, single: 1'b0, dbl: 1'b0, pos: 4'd0});
        send(16'hFFFE, 1'b1, '{data: 11'h7FF, single: 1'b1, dbl: 1'b0, pos: 4'd0});
        send(16'h0020, 1'b1, '{data: 11'h000, single: 1'b1, dbl: 1'b0, pos: 4'd5});
        send(16'h0020, 1'b0, '{data: 11'h002, single: 1'b1, dbl: 1'b0, pos: 4'd5});
        send(16'h0028, 1'b1, '{data: 11'h003, single: 1'b0, dbl: 1'b1, pos: 4'd6});
        d = 11'($urandom);
        c = encode(d);
        send(c, 1'b1, '{data: d, single: 1'b0, dbl: 1'b0, pos: 4'd0});
        send(c ^ 16'h0200, 1'b1, '{data: d, single: 1'b1, dbl: 1'b0, pos: 4'd9});
        send(c ^ 16'h0204, 1'b1, '{data: d ^ 11'h010, single: 1'b0, dbl: 1'b1, pos: 4'd11});
        drain();
        check("double_cnt_after_directed", 32'(double_cnt), 32'(2));

        // Back-to-back stream with a downstream stall in cycles 3..6.
        for (int i = 0; i < 8; i++) w[i] = 11'($urandom) ^ 11'(i << 8) ^ 11'(i);
        idx = 0;
        saw_low = 1'b0;
        for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid  = 1'b1;
            in_code   = encode(w[idx]);
            corr_en   = 1'b1;
            @(negedge clk);
            if (!in_ready) saw_low = 1'b1;
            if (in_ready) begin
                q.push_back('{data: w[idx], single: 1'b0, dbl: 1'b0, pos: 4'd0});
                pushed++;
                idx++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_all_sent", 32'(idx), 32'(8));
        check("stream_in_ready_dropped", 32'(saw_low), 32'(1));
        drain();

        // Counter clear, then saturation with five single-error words.
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check("clr_single_cnt", 32'(single_cnt), 32'(0));
        for (int i = 0; i < 5; i++)
            send(16'h0020, 1'b1, '{data: 11'h000, single: 1'b1, dbl: 1'b0, pos: 4'd5});
        drain();
        check("single_cnt_saturated", 32'(single_cnt), 32'(3));

        // Clear coinciding with a single-error handshake.
        out_ready = 1'b0;
        send(16'h0020, 1'b1, '{data: 11'h000, single: 1'b1, dbl: 1'b0, pos: 4'd5});
        for (int t = 0; t < 10 && !out_valid; t++) begin
            @(posedge clk);
            #1;
        end
        check("clr_word_at_output", 32'(out_valid), 32'(1));
        clr_cnt = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check("clr_beats_increment", 32'(single_cnt), 32'(0));
        drain();

        // Asynchronous reset with two words in flight.
        out_ready = 1'b0;
        send(16'h0020, 1'b1, '{data: 11'h000, single: 1'b1, dbl: 1'b0, pos: 4'd5});
        send(16'h0028, 1'b1, '{data: 11'h003, single: 1'b0, dbl: 1'b1, pos: 4'd6});
        #2;
        rst_n = 1'b0;
        flushed = q.size();
        q.delete();
        exp_single_cnt = 0;
        exp_double_cnt = 0;
        #1;
        check("midrst_out_valid",  32'(out_valid),  32'(0));
        check("midrst_in_ready",   32'(in_ready),   32'(1));
        check("midrst_single_cnt", 32'(single_cnt), 32'(0));
        check("midrst_double_cnt", 32'(double_cnt), 32'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(16'hFFFF, 1'b1, '{data: 11'h7FF, single: 1'b0, dbl: 1'b0, pos: 4'd0});
        drain();
        check("delivered_count", 32'(delivered), 32'(pushed - flushed));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
